soc_system_switch_ctrl: RTL and testbench

SOC_SYSTEM_SWITCH_CTRL -- requirements
Module: soc_system_switch_ctrl

---
 rtl/soc_system_switch_pkg.sv | 16 +
 rtl/soc_system_switch_debounce.sv | 46 ++++
 rtl/soc_system_switch_ctrl.sv | 117 +++++++++++
 tb/tb_soc_system_switch_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/soc_system_switch_pkg.sv
// Shared constants for the switch controller: register map and prescaler width.
package soc_system_switch_pkg;

  localparam int PERIOD_W = 16;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_PERIOD   = 2'd2;
  localparam logic [1:0] ADDR_EDGE     = 2'd3;

  // Reload value for the prescaler; a period of 0 is treated as 1.
  function automatic logic [PERIOD_W-1:0] period_reload(input logic [PERIOD_W-1:0] p);
    return (p == '0) ? '0 : p - 1'b1;
  endfunction

endpackage

// File: rtl/soc_system_switch_debounce.sv
// One switch channel: 2-flop synchronizer, stable-sample counter and debounced level.
module soc_system_switch_debounce #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_raw,
  input  logic tick,
  output logic level,
  output logic toggle
);

  localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             differs;

  assign differs = (sync_reg[1] != level_reg);
  // The level flips on the tick that would bring the counter to STABLE_SAMPLES.
  assign toggle  = tick && differs && (cnt_reg == CNT_W'(STABLE_SAMPLES - 1));
  assign level   = level_reg;

  // Synchronize the raw input, count consecutive differing samples, flip the level when stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], in_raw};
      if (tick) begin
        if (toggle) begin
          level_reg <= ~level_reg;
          cnt_reg   <= '0;
        end else if (differs) begin
          cnt_reg <= cnt_reg + 1'b1;
        end else begin
          cnt_reg <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/soc_system_switch_ctrl.sv
// Avalon-MM switch controller: shared sample prescaler, per-channel debounce,
// edge capture with write-1-to-clear, masked level interrupt.
module soc_system_switch_ctrl
  import soc_system_switch_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int DEFAULT_PERIOD = 50000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic                wr_en;
  logic                rd_en;
  logic                period_wr;
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] presc_reg;
  logic                tick;
  logic [WIDTH-1:0]    level_vec;
  logic [WIDTH-1:0]    toggle_vec;
  logic [WIDTH-1:0]    mask_reg;
  logic [WIDTH-1:0]    edge_reg;
  logic [WIDTH-1:0]    edge_clr;
  logic [WIDTH-1:0]    edge_next;
  logic                irq_reg;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign period_wr = wr_en && (address == ADDR_PERIOD);
  assign tick      = (presc_reg == '0);
  assign unused_wdata = ^writedata[31:PERIOD_W];

  // Prescaler: count down to 0, tick, reload; a PERIOD write reloads immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_reg <= PERIOD_W'(DEFAULT_PERIOD);
      presc_reg  <= PERIOD_W'(DEFAULT_PERIOD - 1);
    end else if (period_wr) begin
      period_reg <= writedata[PERIOD_W-1:0];
      presc_reg  <= period_reload(writedata[PERIOD_W-1:0]);
    end else if (tick) begin
      presc_reg  <= period_reload(period_reg);
    end else begin
      presc_reg  <= presc_reg - 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      soc_system_switch_debounce #(
        .STABLE_SAMPLES(STABLE_SAMPLES)
      ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .in_raw (in_port[gi]),
        .tick   (tick),
        .level  (level_vec[gi]),
        .toggle (toggle_vec[gi])
      );
    end
  endgenerate

  // A new edge overrides a simultaneous write-1 clear of the same bit.
  assign edge_clr  = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
  assign edge_next = (edge_reg & ~edge_clr) | toggle_vec;

  // Control registers, edge capture and the registered interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_reg <= '0;
      edge_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      if (wr_en && (address == ADDR_IRQ_MASK)) begin
        mask_reg <= writedata[WIDTH-1:0];
      end
      edge_reg <= edge_next;
      irq_reg  <= |(edge_reg & mask_reg);
    end
  end

  assign irq = irq_reg;

  // Read data selection; bits beyond each register's width read as 0.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux[WIDTH-1:0]    = level_vec;
      ADDR_IRQ_MASK: rd_mux[WIDTH-1:0]    = mask_reg;
      ADDR_PERIOD:   rd_mux[PERIOD_W-1:0] = period_reg;
      ADDR_EDGE:     rd_mux[WIDTH-1:0]    = edge_reg;
      default:       rd_mux               = '0;
    endcase
  end

  // Registered read port with one cycle of latency; holds when not reading.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_soc_system_switch_ctrl.sv
// Directed bench for soc_system_switch_ctrl: register table plus debounce/edge/irq/reset sequences.
module tb_soc_system_switch_ctrl;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_MASK   = 2'd1;
  localparam logic [1:0] A_PERIOD = 2'd2;
  localparam logic [1:0] A_EDGE   = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  in_port = '0;
  logic        irq;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  soc_system_switch_ctrl #(
    .WIDTH(4),
    .DEFAULT_PERIOD(50000),
    .STABLE_SAMPLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", name, act);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  initial begin
    logic [31:0] rd;

    vecs[0] = '{"mask_0x5",        A_MASK,   32'h0000_0005, 32'h0000_0005};
    vecs[1] = '{"mask_upper_zero", A_MASK,   32'hFFFF_FFFA, 32'h0000_000A};
    vecs[2] = '{"period_0x1234",   A_PERIOD, 32'h0000_1234, 32'h0000_1234};
    vecs[3] = '{"period_16bit",    A_PERIOD, 32'hFFFF_0007, 32'h0000_0007};
    vecs[4] = '{"data_write_ign",  A_DATA,   32'h0000_000F, 32'h0000_0000};
    vecs[5] = '{"edge_w1c_idle",   A_EDGE,   32'h0000_000F, 32'h0000_0000};
    vecs[6] = '{"mask_clear",      A_MASK,   32'h0000_0000, 32'h0000_0000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    bus_read(A_PERIOD, rd); check("rst_period", rd, 32'd50000);
    bus_read(A_MASK, rd);   check("rst_mask", rd, 32'h0);
    bus_read(A_EDGE, rd);   check("rst_edge", rd, 32'h0);
    bus_read(A_DATA, rd);   check("rst_data", rd, 32'h0);

    // Register table
    for (int i = 0; i < 7; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, rd);
      check(vecs[i].name, rd, vecs[i].exp);
    end

    // PERIOD=1, in_port[0] rises: level flips on the 6th edge after the change
    bus_write(A_PERIOD, 32'd1);
    in_port = 4'b0001;
    repeat (5) @(negedge clk);
    bus_read(A_DATA, rd); check("rise_data_before", rd, 32'h0);
    bus_read(A_DATA, rd); check("rise_data_after", rd, 32'h1);
    bus_read(A_EDGE, rd); check("rise_edge", rd, 32'h1);
    check("rise_irq_masked", {31'b0, irq}, 32'h0);
    bus_write(A_EDGE, 32'h1);

    // in_port[1] high for only 3 ticks: rejected as a glitch
    in_port = 4'b0011;
    repeat (3) @(negedge clk);
    in_port = 4'b0001;
    repeat (10) @(negedge clk);
    bus_read(A_DATA, rd); check("glitch_data", rd, 32'h1);
    bus_read(A_EDGE, rd); check("glitch_edge", rd, 32'h0);

    // IRQ_MASK=0x4, in_port[2] toggles: irq one cycle after EDGE[2]
    bus_write(A_MASK, 32'h4);
    in_port = 4'b0101;
    repeat (6) @(negedge clk);
    check("irq_same_cycle_as_edge", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("irq_cycle_after_edge", {31'b0, irq}, 32'h1);
    bus_read(A_EDGE, rd); check("irq_edge", rd, 32'h4);
    bus_write(A_EDGE, 32'h4);
    check("irq_hold_at_clear", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("irq_after_clear", {31'b0, irq}, 32'h0);
    bus_read(A_EDGE, rd); check("irq_edge_cleared", rd, 32'h0);

    // Edge set on bit 3 in the same cycle as a write-1 clear of bit 3
    in_port = 4'b1101;
    repeat (5) @(negedge clk);
    bus_write(A_EDGE, 32'h8);
    bus_read(A_EDGE, rd); check("set_wins_edge", rd, 32'h8);
    check("set_wins_irq", {31'b0, irq}, 32'h0);
    bus_write(A_EDGE, 32'h8);
    bus_read(A_EDGE, rd); check("clear_bit3", rd, 32'h0);

    // PERIOD=0 behaves as 1; chipselect low leaves readdata alone
    bus_write(A_PERIOD, 32'd0);
    bus_read(A_PERIOD, rd); check("period_zero_read", rd, 32'h0);
    in_port = 4'b1111;
    repeat (5) @(negedge clk);
    bus_read(A_DATA, rd); check("p0_data_before", rd, 32'hD);
    bus_read(A_DATA, rd); check("p0_data_after", rd, 32'hF);
    bus_read(A_PERIOD, rd); check("p0_period_again", rd, 32'h0);
    address = A_DATA; chipselect = 1'b0; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    check("cs_low_hold", readdata, 32'h0);
    bus_write(A_EDGE, 32'hF);

    // Reset mid-debounce
    in_port = 4'b0000;
    repeat (8) @(negedge clk);
    bus_write(A_MASK, 32'hF);
    @(negedge clk);
    check("pre_rst_irq", {31'b0, irq}, 32'h1);
    bus_read(A_EDGE, rd); check("pre_rst_edge", rd, 32'hF);
    in_port = 4'b1111;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus_read(A_PERIOD, rd); check("post_rst_period", rd, 32'd50000);
    bus_read(A_MASK, rd);   check("post_rst_mask", rd, 32'h0);
    bus_read(A_EDGE, rd);   check("post_rst_edge", rd, 32'h0);
    bus_read(A_DATA, rd);   check("post_rst_data", rd, 32'h0);
    bus_write(A_PERIOD, 32'd1);
    repeat (3) @(negedge clk);
    bus_read(A_DATA, rd); check("post_rst_full_count", rd, 32'h0);
    bus_read(A_DATA, rd); check("post_rst_data_f", rd, 32'hF);
    bus_read(A_EDGE, rd); check("post_rst_edge_f", rd, 32'hF);
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
